ddr3_req_arbiter: RTL and testbench
===================================

Name: ddr3_req_arbiter

Overview:
Round-robin front-end that shares the single command port of ddr3_controller among NREQ requesters. It issues one controller command per accepted request and tracks outstanding reads in an in-order tag FIFO. It steers each returned read word (dout/raddr/validout) back to the requester that issued the read. It sits between the client blocks and ddr3_controller and owns the controller's cmd/sz/op/din/addr/read inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
TAG_DEPTH, 16, outstanding read commands tracked (power of 2)
IDW, 2, requester-id width, clog2(NREQ)

Ports:
clk  in  1  system clock
resetbar  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_cmd  in  3*NREQ  per-requester cmd (slice i = bits 3i+2:3i)
req_sz  in  2*NREQ  per-requester sz
req_op  in  3*NREQ  per-requester op
req_din  in  16*NREQ  per-requester write data
req_addr  in  25*NREQ  per-requester address
req_ready  out  NREQ  one-hot grant; request accepted when req_valid[i] & req_ready[i]
rsp_valid  out  NREQ  one-hot: rsp_data/rsp_addr belong to requester i this cycle
rsp_data  out  16  returned read word
rsp_addr  out  25  returned read address
ctl_ready  in  1  controller ready (init done)
ctl_notfull  in  1  controller command FIFO not full
ctl_validout  in  1  controller return word available
ctl_dout  in  16  controller return data
ctl_raddr  in  25  controller return address
ctl_cmd  out  3  to controller cmd
ctl_sz  out  2  to controller sz
ctl_op  out  3  to controller op
ctl_din  out  16  to controller din
ctl_addr  out  25  to controller addr
ctl_read  out  1  to controller read (pop return word)
outstanding  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy
err_orphan  out  1  sticky: return word arrived with no outstanding tag

Behaviour:
- Reset (resetbar=0, async): all outputs 0; ctl_cmd=3'b000 (NOP); tag FIFO empty; beat counter 0; RR pointer = NREQ-1, so requester 0 has first priority.
- Command classes: read = {001 SCR, 011 BLR, 101 ATR}; write = {010 SCW, 100 BLW, 110 ATW}; 000 and 111 are illegal. An illegal request is still granted (consumed) but not forwarded and not tagged.
- Grant eligibility in cycle t: ctl_ready=1 and ctl_notfull=1. A read-class request additionally needs tag FIFO count < TAG_DEPTH; an ineligible requester is skipped, not stalled-on.
- Arbitration: search starts at pointer+1 mod NREQ; first eligible req_valid wins. req_ready is combinational from current inputs/state, at most one bit set. Pointer updates to the winner only on grant.
- Issue latency: request granted at edge t appears on ctl_* at t+1 for exactly one cycle; ctl_cmd=000 in every non-issue cycle. The controller keeps >=1 entry of notfull margin.
- Tag push: at grant of a read, push {id, beats}. beats = 1 for SCR/ATR; beats = 8*(sz+1) for BLR (8/16/24/32).
- Return path: ctl_read = ctl_validout (always drain). When the tag FIFO is non-empty, the head id gives rsp_valid[id]=1, rsp_data=ctl_dout, rsp_addr=ctl_raddr, all combinational, same cycle. The beat counter increments per word; on the last beat the head pops and the counter clears.
- ctl_validout with an empty FIFO: word is dropped, no rsp_valid, err_orphan set (cleared only by reset). This covers returns after reset mid-operation.
- Simultaneous push and pop: both take effect. The fullness check uses the pre-edge count, so a full FIFO blocks the read grant even when a pop occurs in the same cycle.
- ctl_ready falling mid-operation: new grants stop; returns continue to be routed.
- outstanding = FIFO count after the edge.

Decomposition:
- Package ddr3_pkg: cmd encodings (CMD_NOP, CMD_SCR, CMD_SCW, CMD_BLR, CMD_BLW, CMD_ATR, CMD_ATW), is_read/is_write functions, beats_of(cmd, sz) function.
- Sub-module ddr3_tag_fifo: synchronous FIFO of {id, beats[5:0]} with count output and async active-low reset.
- The RR arbiter stays inline.

Test Plan:
- Reset, then ctl_ready=0 with all req_valid=1 -> req_ready=0, ctl_cmd=000. Raise ctl_ready -> grant order 0,1,2,3,0 on consecutive cycles, each ctl_cmd one cycle later.
- Requester 2 issues SCR addr=0x0000100; model returns dout=0xBEEF with validout one cycle later -> rsp_valid=4'b0100, rsp_data=0xBEEF, ctl_read=1, outstanding 1->0.
- Req1 BLR sz=01 then req3 SCR -> 16 words routed to req1 (rsp_valid=0010), then 1 word to req3. Pop occurs on the 16th beat.
- Issue 16 reads with no returns -> outstanding=16. A 17th read is withheld while a pending write is granted. One return word with count 16 still blocks reads that cycle; the read is granted the next cycle.
- ctl_notfull=0 for 5 cycles with requests pending -> no grants; RR pointer unchanged; resumes from the same requester.
- Assert resetbar=0 mid-BLR, release, then drive validout -> outputs cleared, words drained via ctl_read, no rsp_valid, err_orphan=1.

Source files
------------

// File: rtl/ddr3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_pkg
//  Purpose  : Shared command encodings and command-class helpers for the
//             ddr3_controller front-end (request arbiter and tag FIFO).
//  Contents : ddr3_cmd_e      - controller command encodings
//             is_read/is_write/is_legal - command class predicates
//             beats_of        - number of return words a read produces
//  Revision : 1.0 - initial release
// ============================================================================
package ddr3_pkg;

    // Width of the per-read beat count carried in each tag (max 32 words).
    localparam int BEAT_W = 6;

    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_SCR = 3'b001,
        CMD_SCW = 3'b010,
        CMD_BLR = 3'b011,
        CMD_BLW = 3'b100,
        CMD_ATR = 3'b101,
        CMD_ATW = 3'b110,
        CMD_ILL = 3'b111
    } ddr3_cmd_e;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_SCR) || (cmd == CMD_BLR) || (cmd == CMD_ATR);
    endfunction

    function automatic logic is_write(input logic [2:0] cmd);
        return (cmd == CMD_SCW) || (cmd == CMD_BLW) || (cmd == CMD_ATW);
    endfunction

    function automatic logic is_legal(input logic [2:0] cmd);
        return is_read(cmd) || is_write(cmd);
    endfunction

    // Burst reads return 8*(sz+1) words; single and atomic reads return one.
    function automatic logic [BEAT_W-1:0] beats_of(input logic [2:0] cmd,
                                                   input logic [1:0] sz);
        logic [BEAT_W-1:0] beats;
        beats = '0;
        case (cmd)
            CMD_BLR: beats = {({1'b0, sz} + 3'd1), 3'b000};
            CMD_SCR,
            CMD_ATR: beats = 6'd1;
            default: beats = '0;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_tag_fifo
//  Purpose  : In-order FIFO of outstanding read tags {requester id, beats}.
//             The head entry is visible combinationally; count is registered.
//  Ports    : clk, resetbar (async active-low)
//             push/push_data - enqueue a tag (ignored when full)
//             pop            - dequeue the head (ignored when empty)
//             head, empty, count - current head entry and occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module ddr3_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetbar,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & (r_count != (c_aw+1)'(DEPTH));
    assign w_do_pop  = pop  & (r_count != '0);

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ddr3_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_req_arbiter
//  Purpose  : Round-robin front-end sharing the ddr3_controller command port
//             among NREQ requesters. Issues one controller command per
//             accepted request, tracks outstanding reads in an in-order tag
//             FIFO and steers returned read words back to their requester.
//  Ports    : req_*        - packed per-requester request bundles (in)
//             req_ready    - one-hot grant (out)
//             rsp_*        - routed read return (out)
//             ctl_ready/ctl_notfull/ctl_validout/ctl_dout/ctl_raddr (in)
//             ctl_cmd/sz/op/din/addr/read - controller command port (out)
//             outstanding  - tag FIFO occupancy
//             err_orphan   - sticky: return word with no outstanding tag
//  Revision : 1.0 - initial release
// ============================================================================
module ddr3_req_arbiter
    import ddr3_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 16,
    parameter int IDW       = 2
) (
    input  logic                        clk,
    input  logic                        resetbar,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [3*NREQ-1:0]           req_cmd,
    input  logic [2*NREQ-1:0]           req_sz,
    input  logic [3*NREQ-1:0]           req_op,
    input  logic [16*NREQ-1:0]          req_din,
    input  logic [25*NREQ-1:0]          req_addr,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [15:0]                 rsp_data,
    output logic [24:0]                 rsp_addr,
    input  logic                        ctl_ready,
    input  logic                        ctl_notfull,
    input  logic                        ctl_validout,
    input  logic [15:0]                 ctl_dout,
    input  logic [24:0]                 ctl_raddr,
    output logic [2:0]                  ctl_cmd,
    output logic [1:0]                  ctl_sz,
    output logic [2:0]                  ctl_op,
    output logic [15:0]                 ctl_din,
    output logic [24:0]                 ctl_addr,
    output logic                        ctl_read,
    output logic [$clog2(TAG_DEPTH):0]  outstanding,
    output logic                        err_orphan
);

    localparam int              c_cnt_w = $clog2(TAG_DEPTH) + 1;
    localparam int              c_tag_w = IDW + BEAT_W;
    localparam logic [NREQ-1:0] c_one   = NREQ'(1);

    // Unpacked views of the request bundles.
    logic [2:0]  w_cmd_a  [NREQ];
    logic [1:0]  w_sz_a   [NREQ];
    logic [2:0]  w_op_a   [NREQ];
    logic [15:0] w_din_a  [NREQ];
    logic [24:0] w_addr_a [NREQ];

    logic [NREQ-1:0]     w_elig;
    logic [NREQ-1:0]     w_grant;
    logic                w_any_grant;
    logic [IDW-1:0]      w_win;
    logic [IDW-1:0]      r_ptr;

    logic [2:0]          w_sel_cmd;
    logic [1:0]          w_sel_sz;
    logic [2:0]          w_sel_op;
    logic [15:0]         w_sel_din;
    logic [24:0]         w_sel_addr;

    logic [2:0]          r_ctl_cmd;
    logic [1:0]          r_ctl_sz;
    logic [2:0]          r_ctl_op;
    logic [15:0]         r_ctl_din;
    logic [24:0]         r_ctl_addr;

    logic                w_push;
    logic [c_tag_w-1:0]  w_push_data;
    logic                w_pop;
    logic [c_tag_w-1:0]  w_head;
    logic [IDW-1:0]      w_head_id;
    logic [BEAT_W-1:0]   w_head_beats;
    logic                w_empty;
    logic                w_full;
    logic [c_cnt_w-1:0]  w_count;

    logic                w_rsp_fire;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_err;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_cmd_a[i]  = req_cmd[3*i +: 3];
            assign w_sz_a[i]   = req_sz[2*i +: 2];
            assign w_op_a[i]   = req_op[3*i +: 3];
            assign w_din_a[i]  = req_din[16*i +: 16];
            assign w_addr_a[i] = req_addr[25*i +: 25];
        end
    endgenerate

    // Fullness uses the pre-edge count, so a pop in the same cycle does not
    // open a slot for a read grant until the following cycle.
    assign w_full = (w_count == c_cnt_w'(TAG_DEPTH));

    // Illegal commands are eligible like writes: they are consumed silently.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_elig
            assign w_elig[i] = req_valid[i] & ctl_ready & ctl_notfull &
                               (~is_read(w_cmd_a[i]) | ~w_full);
        end
    endgenerate

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_grant = '0;
        w_win   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            int v;
            v = int'(r_ptr) + k;
            if (v >= NREQ) begin
                v = v - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if ((i == v) && w_elig[i] && (w_grant == '0)) begin
                    w_grant[i] = 1'b1;
                    w_win      = IDW'(i);
                end
            end
        end
    end

    assign w_any_grant = |w_grant;
    assign req_ready   = w_grant;

    always_comb begin
        w_sel_cmd  = '0;
        w_sel_sz   = '0;
        w_sel_op   = '0;
        w_sel_din  = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_cmd  = w_cmd_a[i];
                w_sel_sz   = w_sz_a[i];
                w_sel_op   = w_op_a[i];
                w_sel_din  = w_din_a[i];
                w_sel_addr = w_addr_a[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (w_any_grant) begin
            r_ptr <= w_win;
        end
    end

    // Command register: the controller sees each accepted command for one
    // cycle; every other cycle (including illegal grants) presents a NOP.
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_ctl_cmd  <= CMD_NOP;
            r_ctl_sz   <= '0;
            r_ctl_op   <= '0;
            r_ctl_din  <= '0;
            r_ctl_addr <= '0;
        end else if (w_any_grant && is_legal(w_sel_cmd)) begin
            r_ctl_cmd  <= w_sel_cmd;
            r_ctl_sz   <= w_sel_sz;
            r_ctl_op   <= w_sel_op;
            r_ctl_din  <= w_sel_din;
            r_ctl_addr <= w_sel_addr;
        end else begin
            r_ctl_cmd  <= CMD_NOP;
            r_ctl_sz   <= '0;
            r_ctl_op   <= '0;
            r_ctl_din  <= '0;
            r_ctl_addr <= '0;
        end
    end

    assign ctl_cmd  = r_ctl_cmd;
    assign ctl_sz   = r_ctl_sz;
    assign ctl_op   = r_ctl_op;
    assign ctl_din  = r_ctl_din;
    assign ctl_addr = r_ctl_addr;

    assign w_push      = w_any_grant & is_read(w_sel_cmd);
    assign w_push_data = {w_win, beats_of(w_sel_cmd, w_sel_sz)};

    ddr3_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (c_tag_w)
    ) u_tag_fifo (
        .clk       (clk),
        .resetbar  (resetbar),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_head_id    = w_head[c_tag_w-1 -: IDW];
    assign w_head_beats = w_head[BEAT_W-1:0];

    // Return path: words are always drained; only words that match an
    // outstanding tag are routed to a requester.
    assign ctl_read   = ctl_validout;
    assign w_rsp_fire = ctl_validout & ~w_empty;
    assign w_pop      = w_rsp_fire & ((r_beat + 1'b1) == w_head_beats);

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_beat <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_rsp_fire) begin
                r_beat <= w_pop ? '0 : (r_beat + 1'b1);
            end
            if (ctl_validout && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_valid   = w_rsp_fire ? (c_one << w_head_id) : '0;
    assign rsp_data    = w_rsp_fire ? ctl_dout  : '0;
    assign rsp_addr    = w_rsp_fire ? ctl_raddr : '0;
    assign outstanding = w_count;
    assign err_orphan  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_req_arbiter
//  Purpose  : Self-checking bench for ddr3_req_arbiter: table of arbitration
//             vectors followed by hand-written read/return sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_req_arbiter;
    import ddr3_pkg::*;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               resetbar;
    logic [NREQ-1:0]    req_valid;
    logic [3*NREQ-1:0]  req_cmd;
    logic [2*NREQ-1:0]  req_sz;
    logic [3*NREQ-1:0]  req_op;
    logic [16*NREQ-1:0] req_din;
    logic [25*NREQ-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [15:0]        rsp_data;
    logic [24:0]        rsp_addr;
    logic               ctl_ready;
    logic               ctl_notfull;
    logic               ctl_validout;
    logic [15:0]        ctl_dout;
    logic [24:0]        ctl_raddr;
    logic [2:0]         ctl_cmd;
    logic [1:0]         ctl_sz;
    logic [2:0]         ctl_op;
    logic [15:0]        ctl_din;
    logic [24:0]        ctl_addr;
    logic               ctl_read;
    logic [4:0]         outstanding;
    logic               err_orphan;

    logic [2:0]  t_cmd  [NREQ];
    logic [1:0]  t_sz   [NREQ];
    logic [2:0]  t_op   [NREQ];
    logic [15:0] t_din  [NREQ];
    logic [24:0] t_addr [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_cmd  = '0;
        req_sz   = '0;
        req_op   = '0;
        req_din  = '0;
        req_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_cmd[3*i +: 3]   = t_cmd[i];
            req_sz[2*i +: 2]    = t_sz[i];
            req_op[3*i +: 3]    = t_op[i];
            req_din[16*i +: 16] = t_din[i];
            req_addr[25*i +: 25] = t_addr[i];
        end
    end

    ddr3_req_arbiter #(
        .NREQ      (4),
        .TAG_DEPTH (16),
        .IDW       (2)
    ) dut (
        .clk          (clk),
        .resetbar     (resetbar),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_sz       (req_sz),
        .req_op       (req_op),
        .req_din      (req_din),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .ctl_ready    (ctl_ready),
        .ctl_notfull  (ctl_notfull),
        .ctl_validout (ctl_validout),
        .ctl_dout     (ctl_dout),
        .ctl_raddr    (ctl_raddr),
        .ctl_cmd      (ctl_cmd),
        .ctl_sz       (ctl_sz),
        .ctl_op       (ctl_op),
        .ctl_din      (ctl_din),
        .ctl_addr     (ctl_addr),
        .ctl_read     (ctl_read),
        .outstanding  (outstanding),
        .err_orphan   (err_orphan)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic        nf;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_cmd;
        logic [24:0] exp_addr;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request cycle: drive valids, check grant, check issued command.
    task automatic cyc(input logic [3:0] valid, input logic [3:0] exp_rdy,
                       input logic [2:0] exp_cmd, input string tag);
        @(negedge clk);
        req_valid = valid;
        #1;
        check({tag, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " ctl_cmd"}, 64'(ctl_cmd), 64'(exp_cmd));
    endtask

    // One return word from the controller with the expected routing.
    task automatic ret(input logic [15:0] d, input logic [24:0] a,
                       input logic [3:0] exp_rsp, input string tag);
        @(negedge clk);
        req_valid    = '0;
        ctl_validout = 1'b1;
        ctl_dout     = d;
        ctl_raddr    = a;
        #1;
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(exp_rsp));
        check({tag, " rsp_data"}, 64'(rsp_data), (exp_rsp != 4'b0) ? 64'(d) : 64'h0);
        check({tag, " rsp_addr"}, 64'(rsp_addr), (exp_rsp != 4'b0) ? 64'(a) : 64'h0);
        check({tag, " ctl_read"}, 64'(ctl_read), 64'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid    = '0;
        ctl_validout = 1'b0;
    endtask

    initial begin
        // Arbitration table: all requesters hold single-cycle writes.
        vecs[0]  = '{4'hF, 1'b0, 1'b1, 4'b0000, CMD_NOP, 25'h0};
        vecs[1]  = '{4'hF, 1'b1, 1'b1, 4'b0001, CMD_SCW, 25'h1000};
        vecs[2]  = '{4'hF, 1'b1, 1'b1, 4'b0010, CMD_SCW, 25'h1001};
        vecs[3]  = '{4'hF, 1'b1, 1'b1, 4'b0100, CMD_SCW, 25'h1002};
        vecs[4]  = '{4'hF, 1'b1, 1'b1, 4'b1000, CMD_SCW, 25'h1003};
        vecs[5]  = '{4'hF, 1'b1, 1'b1, 4'b0001, CMD_SCW, 25'h1000};
        vecs[6]  = '{4'hF, 1'b1, 1'b0, 4'b0000, CMD_NOP, 25'h0};
        vecs[7]  = '{4'hF, 1'b1, 1'b0, 4'b0000, CMD_NOP, 25'h0};
        vecs[8]  = '{4'hF, 1'b1, 1'b0, 4'b0000, CMD_NOP, 25'h0};
        vecs[9]  = '{4'hF, 1'b1, 1'b0, 4'b0000, CMD_NOP, 25'h0};
        vecs[10] = '{4'hF, 1'b1, 1'b0, 4'b0000, CMD_NOP, 25'h0};
        vecs[11] = '{4'hF, 1'b1, 1'b1, 4'b0010, CMD_SCW, 25'h1001};
        vecs[12] = '{4'h9, 1'b1, 1'b1, 4'b1000, CMD_SCW, 25'h1003};
        vecs[13] = '{4'h9, 1'b1, 1'b1, 4'b0001, CMD_SCW, 25'h1000};
        vecs[14] = '{4'h4, 1'b1, 1'b1, 4'b0100, CMD_SCW, 25'h1002};
        vecs[15] = '{4'h0, 1'b1, 1'b1, 4'b0000, CMD_NOP, 25'h0};
        vecs[16] = '{4'hF, 1'b0, 1'b1, 4'b0000, CMD_NOP, 25'h0};

        for (int i = 0; i < NREQ; i++) begin
            t_cmd[i]  = CMD_SCW;
            t_sz[i]   = 2'b00;
            t_op[i]   = 3'(i);
            t_din[i]  = 16'hA000 + 16'(i);
            t_addr[i] = 25'h1000 + 25'(i);
        end

        resetbar     = 1'b0;
        req_valid    = '0;
        ctl_ready    = 1'b0;
        ctl_notfull  = 1'b1;
        ctl_validout = 1'b0;
        ctl_dout     = '0;
        ctl_raddr    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctl_cmd", 64'(ctl_cmd), 64'h0);
        check("reset outstanding", 64'(outstanding), 64'h0);
        check("reset err_orphan", 64'(err_orphan), 64'h0);
        check("reset req_ready", 64'(req_ready), 64'h0);
        check("reset rsp_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        resetbar = 1'b1;

        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            req_valid   = vecs[v].valid;
            ctl_ready   = vecs[v].rdy;
            ctl_notfull = vecs[v].nf;
            #1;
            check($sformatf("vec%0d req_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ctl_cmd", v), 64'(ctl_cmd), 64'(vecs[v].exp_cmd));
            check($sformatf("vec%0d ctl_addr", v), 64'(ctl_addr), 64'(vecs[v].exp_addr));
        end
        @(negedge clk);
        req_valid   = '0;
        ctl_ready   = 1'b1;
        ctl_notfull = 1'b1;
        check("writes untagged", 64'(outstanding), 64'h0);

        // Single read from requester 2, returned one cycle later.
        t_cmd[2]  = CMD_SCR;
        t_addr[2] = 25'h0000100;
        cyc(4'b0100, 4'b0100, CMD_SCR, "scr2");
        check("scr2 ctl_addr", 64'(ctl_addr), 64'h100);
        check("scr2 outstanding", 64'(outstanding), 64'h1);
        ret(16'hBEEF, 25'h0000100, 4'b0100, "scr2_ret");
        check("scr2_ret outstanding", 64'(outstanding), 64'h0);
        idle();

        // Illegal command: consumed, not forwarded, not tagged.
        t_cmd[3] = 3'b111;
        cyc(4'b1000, 4'b1000, CMD_NOP, "illegal");
        check("illegal outstanding", 64'(outstanding), 64'h0);

        // Burst read of 16 words to req1, then single read to req3.
        t_cmd[1] = CMD_BLR;
        t_sz[1]  = 2'b01;
        t_cmd[3] = CMD_SCR;
        cyc(4'b0010, 4'b0010, CMD_BLR, "blr1");
        check("blr1 ctl_sz", 64'(ctl_sz), 64'h1);
        cyc(4'b1000, 4'b1000, CMD_SCR, "scr3");
        check("blr1+scr3 outstanding", 64'(outstanding), 64'h2);
        ctl_ready = 1'b0;  // returns must keep flowing with grants stopped
        for (int b = 0; b < 16; b++) begin
            ret(16'h2000 + 16'(b), 25'h2000 + 25'(b), 4'b0010, $sformatf("blr1_ret%0d", b));
            check($sformatf("blr1_ret%0d outstanding", b), 64'(outstanding),
                  (b == 15) ? 64'h1 : 64'h2);
        end
        ret(16'h3333, 25'h3000, 4'b1000, "scr3_ret");
        check("scr3_ret outstanding", 64'(outstanding), 64'h0);
        idle();
        ctl_ready = 1'b1;

        // Fill the tag FIFO from requester 0.
        t_cmd[0] = CMD_SCR;
        t_cmd[2] = CMD_SCW;
        for (int k = 0; k < 16; k++) begin
            cyc(4'b0001, 4'b0001, CMD_SCR, $sformatf("fill%0d", k));
        end
        check("fill outstanding", 64'(outstanding), 64'h10);

        // Full: read from req1 skipped, write from req2 granted.
        t_cmd[1] = CMD_SCR;
        t_sz[1]  = 2'b00;
        cyc(4'b0110, 4'b0100, CMD_SCW, "full_wr");
        check("full_wr outstanding", 64'(outstanding), 64'h10);

        // Pop in the same cycle still blocks the read grant.
        @(negedge clk);
        req_valid    = 4'b0010;
        ctl_validout = 1'b1;
        ctl_dout     = 16'h5555;
        ctl_raddr    = 25'h5555;
        #1;
        check("full_pop req_ready", 64'(req_ready), 64'h0);
        check("full_pop rsp_valid", 64'(rsp_valid), 64'h1);
        @(posedge clk);
        #1;
        check("full_pop ctl_cmd", 64'(ctl_cmd), 64'h0);
        check("full_pop outstanding", 64'(outstanding), 64'hF);
        ctl_validout = 1'b0;
        cyc(4'b0010, 4'b0010, CMD_SCR, "after_pop");
        check("after_pop outstanding", 64'(outstanding), 64'h10);
        for (int k = 0; k < 16; k++) begin
            ret(16'(k), 25'(k), (k < 15) ? 4'b0001 : 4'b0010, $sformatf("drain%0d", k));
        end
        check("drain outstanding", 64'(outstanding), 64'h0);
        idle();

        // Reset in the middle of a 32-word burst, then orphan returns.
        t_cmd[1] = CMD_BLR;
        t_sz[1]  = 2'b11;
        cyc(4'b0010, 4'b0010, CMD_BLR, "blr32");
        check("blr32 ctl_sz", 64'(ctl_sz), 64'h3);
        for (int k = 0; k < 3; k++) begin
            ret(16'h7000 + 16'(k), 25'h7000 + 25'(k), 4'b0010, $sformatf("blr32_ret%0d", k));
        end
        check("pre-reset err_orphan", 64'(err_orphan), 64'h0);
        check("pre-reset outstanding", 64'(outstanding), 64'h1);
        @(negedge clk);
        #2;
        resetbar = 1'b0;
        #1;
        check("midreset ctl_cmd", 64'(ctl_cmd), 64'h0);
        check("midreset outstanding", 64'(outstanding), 64'h0);
        check("midreset rsp_valid", 64'(rsp_valid), 64'h0);
        check("midreset err_orphan", 64'(err_orphan), 64'h0);
        @(negedge clk);
        resetbar = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ret(16'h7100 + 16'(k), 25'h7100 + 25'(k), 4'b0000, $sformatf("orphan%0d", k));
            check($sformatf("orphan%0d err_orphan", k), 64'(err_orphan), 64'h1);
        end
        idle();
        @(posedge clk);
        #1;
        check("sticky err_orphan", 64'(err_orphan), 64'h1);
        check("final outstanding", 64'(outstanding), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
